// File: rtl/jtpopeye_obj_pkg.sv
// Shared definitions for the ping-pong object line buffer: scan FSM states,
// width helpers and the field layout of a stored entry.
package jtpopeye_obj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } obj_state_t;

    function automatic int addr_w(input int slots);
        return $clog2(slots);
    endfunction

    function automatic int sub_w(input int obj_h);
        return $clog2(obj_h);
    endfunction

    // Entry layout: {payload, sub-row}; sub-row occupies the low bits.
    localparam int ENTRY_SUB_LSB = 0;

    function automatic int entry_data_lsb(input int obj_h);
        return sub_w(obj_h);
    endfunction

endpackage

// File: rtl/jtpopeye_objlist_bank.sv
// One line-buffer bank: 1R/1W synchronous RAM with registered read, both
// ports qualified by the pixel clock enable.
module jtpopeye_objlist_bank #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 24,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             pxl_cen,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (pxl_cen && we) begin
            mem[wr_addr] <= wr_data;
        end
        if (pxl_cen && re) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jtpopeye_objlist.sv
// Ping-pong object line buffer: collects the in-range objects for the next
// line into one bank while the renderer reads the previous line's bank.
module jtpopeye_objlist
    import jtpopeye_obj_pkg::*;
#(
    parameter  int VW    = 8,
    parameter  int DW    = 20,
    parameter  int SLOTS = 64,
    parameter  int OBJ_H = 16,
    localparam int AW    = addr_w(SLOTS),
    localparam int SW    = sub_w(OBJ_H),
    localparam int EW    = DW + SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          line_start,
    input  logic [VW-1:0] vpos,
    input  logic          obj_valid,
    output logic          obj_ready,
    input  logic [VW-1:0] obj_y,
    input  logic          obj_vflip,
    input  logic [DW-1:0] obj_data,
    input  logic          obj_last,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic          rd_hit,
    output logic [EW-1:0] rd_data,
    output logic [AW:0]   rd_count,
    output logic          overflow,
    output logic          busy
);

    localparam int          DATA_LSB = entry_data_lsb(OBJ_H);
    localparam logic [AW:0] SLOTS_C  = (AW+1)'(SLOTS);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    obj_state_t  state_reg, state_next;
    logic        bank_sel_reg, bank_sel_next;
    logic [AW:0] wr_count_reg, wr_count_next;
    logic [AW:0] rd_count_reg, rd_count_next;
    logic        ovf_pending_reg, ovf_pending_next;
    logic        overflow_reg, overflow_next;
    logic        rd_valid_reg, rd_valid_next;
    logic        rd_hit_reg, rd_hit_next;
    logic        rd_bank_reg, rd_bank_next;

    logic [VW-1:0] row;
    logic [SW-1:0] sub;
    logic          obj_hit;
    logic          accept;
    logic          wr_en;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] bank_q [2];

    // Row inside the object; modular subtraction handles objects straddling Y=0.
    assign row     = vpos - obj_y;
    assign obj_hit = ~|row[VW-1:SW];
    assign sub     = row[SW-1:0] ^ {SW{obj_vflip}};

    always_comb begin
        wr_data = '0;
        wr_data[DATA_LSB +: DW]      = obj_data;
        wr_data[ENTRY_SUB_LSB +: SW] = sub;
    end

    assign busy      = (state_reg == SCAN) || (state_reg == FULL);
    assign obj_ready = pxl_cen && busy && !line_start;
    assign accept    = obj_ready && obj_valid;

    always_comb begin
        state_next       = state_reg;
        bank_sel_next    = bank_sel_reg;
        wr_count_next    = wr_count_reg;
        rd_count_next    = rd_count_reg;
        ovf_pending_next = ovf_pending_reg;
        overflow_next    = overflow_reg;
        rd_valid_next    = rd_valid_reg;
        rd_hit_next      = rd_hit_reg;
        rd_bank_next     = rd_bank_reg;
        wr_en            = 1'b0;
        if (pxl_cen) begin
            if (line_start) begin
                bank_sel_next    = ~bank_sel_reg;
                rd_count_next    = wr_count_reg;
                overflow_next    = ovf_pending_reg;
                wr_count_next    = '0;
                ovf_pending_next = 1'b0;
                state_next       = SCAN;
            end else if (accept) begin
                if (obj_hit) begin
                    if (wr_count_reg < SLOTS_C) begin
                        wr_en         = 1'b1;
                        wr_count_next = wr_count_reg + CNT_ONE;
                    end else begin
                        ovf_pending_next = 1'b1;
                        state_next       = FULL;
                    end
                end
                if (obj_last) begin
                    state_next = DONE;
                end
            end
            // Read side sees the pre-swap bank and count in a line_start cen.
            rd_valid_next = rd_en;
            rd_hit_next   = rd_en && ({1'b0, rd_addr} < rd_count_reg);
            if (rd_en) begin
                rd_bank_next = ~bank_sel_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            bank_sel_reg    <= 1'b0;
            wr_count_reg    <= '0;
            rd_count_reg    <= '0;
            ovf_pending_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            rd_valid_reg    <= 1'b0;
            rd_hit_reg      <= 1'b0;
            rd_bank_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bank_sel_reg    <= bank_sel_next;
            wr_count_reg    <= wr_count_next;
            rd_count_reg    <= rd_count_next;
            ovf_pending_reg <= ovf_pending_next;
            overflow_reg    <= overflow_next;
            rd_valid_reg    <= rd_valid_next;
            rd_hit_reg      <= rd_hit_next;
            rd_bank_reg     <= rd_bank_next;
        end
    end

    // Bank gi is written while selected and read while the other one is.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic BANK_ID = 1'(gi);
        jtpopeye_objlist_bank #(
            .DEPTH (SLOTS),
            .WIDTH (EW)
        ) u_bank (
            .clk     (clk),
            .pxl_cen (pxl_cen),
            .we      (wr_en && (bank_sel_reg == BANK_ID)),
            .wr_addr (wr_count_reg[AW-1:0]),
            .wr_data (wr_data),
            .re      (rd_en && (bank_sel_reg != BANK_ID)),
            .rd_addr (rd_addr),
            .rd_q    (bank_q[gi])
        );
    end

    // RAM output is undefined after reset, so it only shows while rd_valid.
    assign rd_data  = rd_valid_reg ? bank_q[rd_bank_reg] : '0;
    assign rd_valid = rd_valid_reg;
    assign rd_hit   = rd_hit_reg;
    assign rd_count = rd_count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_jtpopeye_objlist.sv
// Self-checking bench for jtpopeye_objlist: hit-test vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_jtpopeye_objlist;

    localparam int VW    = 8;
    localparam int DW    = 20;
    localparam int SLOTS = 4;
    localparam int OBJ_H = 16;
    localparam int AW    = 2;
    localparam int SW    = 4;
    localparam int EW    = DW + SW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pxl_cen;
    logic          line_start;
    logic [VW-1:0] vpos;
    logic          obj_valid;
    logic          obj_ready;
    logic [VW-1:0] obj_y;
    logic          obj_vflip;
    logic [DW-1:0] obj_data;
    logic          obj_last;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          rd_hit;
    logic [EW-1:0] rd_data;
    logic [AW:0]   rd_count;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model: lists of entries per line rather than banks/counters.
    bit            m_busy;
    logic [EW-1:0] m_wr_q[$];
    logic [EW-1:0] m_rd_list[$];
    int            m_hits;
    int            m_rd_count;
    bit            m_ovf;
    bit            m_rd_valid;
    bit            m_rd_hit;
    logic [EW-1:0] m_rd_data;

    jtpopeye_objlist #(
        .VW(VW), .DW(DW), .SLOTS(SLOTS), .OBJ_H(OBJ_H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pxl_cen    (pxl_cen),
        .line_start (line_start),
        .vpos       (vpos),
        .obj_valid  (obj_valid),
        .obj_ready  (obj_ready),
        .obj_y      (obj_y),
        .obj_vflip  (obj_vflip),
        .obj_data   (obj_data),
        .obj_last   (obj_last),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data),
        .rd_count   (rd_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_wr_q.delete();
        m_rd_list.delete();
        m_hits = 0;
        m_rd_count = 0;
        m_ovf = 0;
        m_rd_valid = 0;
        m_rd_hit = 0;
        m_rd_data = '0;
    endtask

    task automatic idle_inputs();
        pxl_cen    = 1'b1;
        line_start = 1'b0;
        obj_valid  = 1'b0;
        obj_y      = '0;
        obj_vflip  = 1'b0;
        obj_data   = '0;
        obj_last   = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
    endtask

    // One clock: check combinational ready, advance the model, check registers.
    task automatic cycle();
        logic [VW-1:0] row;
        bit exp_ready;
        exp_ready = pxl_cen && m_busy && !line_start;
        #1;
        check("obj_ready", obj_ready, exp_ready);
        @(posedge clk);
        if (pxl_cen) begin
            if (rd_en) begin
                m_rd_valid = 1;
                m_rd_hit = int'(rd_addr) < m_rd_count;
                if (m_rd_hit) m_rd_data = m_rd_list[rd_addr];
            end else begin
                m_rd_valid = 0;
                m_rd_hit = 0;
            end
            if (line_start) begin
                m_rd_list = m_wr_q;
                m_rd_count = (m_hits > SLOTS) ? SLOTS : m_hits;
                m_ovf = m_hits > SLOTS;
                m_wr_q.delete();
                m_hits = 0;
                m_busy = 1;
            end else if (exp_ready && obj_valid) begin
                row = vpos - obj_y;
                if (int'(row) < OBJ_H) begin
                    m_hits++;
                    if (m_wr_q.size() < SLOTS)
                        m_wr_q.push_back({obj_data, row[SW-1:0] ^ {SW{obj_vflip}}});
                end
                if (obj_last) m_busy = 0;
            end
        end
        #1;
        check("busy", busy, m_busy);
        check("rd_count", rd_count, m_rd_count);
        check("overflow", overflow, m_ovf);
        check("rd_valid", rd_valid, m_rd_valid);
        if (m_rd_valid) check("rd_hit", rd_hit, m_rd_hit);
        if (m_rd_valid && m_rd_hit) check("rd_data", rd_data, m_rd_data);
    endtask

    task automatic ls_cycle();
        line_start = 1'b1;
        cycle();
        line_start = 1'b0;
    endtask

    task automatic obj_cycle(input logic [VW-1:0] y, input logic vf,
                             input logic [DW-1:0] d, input logic last);
        obj_valid = 1'b1; obj_y = y; obj_vflip = vf; obj_data = d; obj_last = last;
        cycle();
        obj_valid = 1'b0; obj_last = 1'b0;
    endtask

    task automatic read_cycle(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        cycle();
        rd_en = 1'b0;
    endtask

    typedef struct {
        logic [VW-1:0] vpos;
        logic [VW-1:0] y;
        logic          vflip;
        logic          exp_hit;
        logic [SW-1:0] exp_sub;
    } hvec_t;

    hvec_t tbl[8];
    logic [DW-1:0] bank_a[4];

    initial begin
        tbl[0] = '{8'h20, 8'h1C, 1'b0, 1'b1, 4'd4};
        tbl[1] = '{8'h20, 8'h30, 1'b0, 1'b0, 4'd0};
        tbl[2] = '{8'h20, 8'h11, 1'b0, 1'b1, 4'd15};
        tbl[3] = '{8'h20, 8'h10, 1'b0, 1'b0, 4'd0};
        tbl[4] = '{8'h02, 8'hFE, 1'b1, 1'b1, 4'd11};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 4'd15};
        tbl[6] = '{8'h05, 8'h06, 1'b0, 1'b0, 4'd0};
        tbl[7] = '{8'hFF, 8'hF5, 1'b1, 1'b1, 4'd5};

        // Reset state
        idle_inputs();
        vpos = '0;
        model_reset();
        rst_n = 1'b0;
        #12;
        check("reset_obj_ready", obj_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_hit", rd_hit, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_count", rd_count, 0);
        check("reset_overflow", overflow, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: outputs checked");

        // Basic hit: only 0x1C is within 16 lines of 0x20
        vpos = 8'h20;
        ls_cycle();
        obj_cycle(8'h1C, 0, 20'h12345, 0);
        obj_cycle(8'h30, 0, 20'h23456, 0);
        obj_cycle(8'h10, 0, 20'h34567, 1);
        ls_cycle();
        check("basic_count", rd_count, 1);
        read_cycle(0);
        check("basic_hit0", rd_hit, 1);
        check("basic_sub0", rd_data[SW-1:0], 4);
        check("basic_payload0", rd_data[EW-1:SW], 20'h12345);
        read_cycle(1);
        check("basic_hit1", rd_hit, 0);
        $display("basic: rd_count=%0d", rd_count);

        // Hit-test vector table
        for (int i = 0; i < 8; i++) begin
            vpos = tbl[i].vpos;
            ls_cycle();
            obj_cycle(tbl[i].y, tbl[i].vflip, 20'hA0000 + 20'(i), 1);
            ls_cycle();
            read_cycle(0);
            check("tbl_count", rd_count, tbl[i].exp_hit);
            check("tbl_hit", rd_hit, tbl[i].exp_hit);
            if (tbl[i].exp_hit)
                check("tbl_data", rd_data, {20'hA0000 + 20'(i), tbl[i].exp_sub});
            $display("vector %0d: vpos=%0h y=%0h vflip=%0d hit=%0d data=%0h",
                     i, tbl[i].vpos, tbl[i].y, tbl[i].vflip, rd_hit, rd_data);
        end

        // Overflow: six hits into four slots
        vpos = 8'h40;
        ls_cycle();
        for (int k = 0; k < 6; k++)
            obj_cycle(8'h40 - 8'(k), 0, 20'hB0000 + 20'(k), (k == 5));
        ls_cycle();
        check("ovf_count", rd_count, 4);
        check("ovf_flag", overflow, 1);
        read_cycle(3);
        check("ovf_data3", rd_data, {20'hB0003, 4'd3});
        obj_cycle(8'h3F, 0, 20'hB0010, 1);
        ls_cycle();
        check("ovf_clear_flag", overflow, 0);
        check("ovf_clear_count", rd_count, 1);
        $display("overflow: sequence done");

        // Swap priority: object alongside line_start is held off one cen
        vpos = 8'h50;
        obj_valid = 1'b1; obj_y = 8'h48; obj_vflip = 1'b0; obj_data = 20'h5A5A5; obj_last = 1'b0;
        line_start = 1'b1;
        #1;
        check("swap_ready_low", obj_ready, 0);
        cycle();
        line_start = 1'b0;
        obj_last = 1'b1;
        cycle();
        obj_valid = 1'b0; obj_last = 1'b0;
        ls_cycle();
        read_cycle(0);
        check("swap_data", rd_data, {20'h5A5A5, 4'd8});
        $display("swap: data=%0h", rd_data);

        // Ping-pong isolation
        vpos = 8'h60;
        ls_cycle();
        for (int k = 0; k < 4; k++) begin
            bank_a[k] = 20'hC0000 + 20'(k * 17);
            obj_cycle(8'h60 - 8'(k), 0, bank_a[k], (k == 3));
        end
        ls_cycle();
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b1; rd_addr = AW'(k % 4);
            obj_valid = (k < 4); obj_y = 8'h60 - 8'(k); obj_data = 20'hD0000 + 20'(k);
            obj_last = (k == 3);
            cycle();
            check("pingpong_a", rd_data[EW-1:SW], bank_a[k % 4]);
        end
        rd_en = 1'b0; obj_valid = 1'b0; obj_last = 1'b0;
        ls_cycle();
        for (int k = 0; k < 4; k++) begin
            read_cycle(AW'(k));
            check("pingpong_b", rd_data[EW-1:SW], 20'hD0000 + 20'(k));
        end
        $display("pingpong: sequence done");

        // Reset mid-scan with three entries written
        vpos = 8'h70;
        ls_cycle();
        for (int k = 0; k < 3; k++) obj_cycle(8'h70 - 8'(k), 0, 20'hE0000 + 20'(k), 0);
        obj_valid = 1'b1; obj_y = 8'h70;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_count", rd_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_ready", obj_ready, 0);
        idle_inputs();
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        read_cycle(0);
        check("rst_read_hit", rd_hit, 0);
        ls_cycle();
        read_cycle(0);
        check("rst_read_hit2", rd_hit, 0);
        $display("reset mid-scan: sequence done");

        // Randomized lines
        for (int ln = 0; ln < 40; ln++) begin
            vpos = 8'($urandom);
            pxl_cen = 1'b1;
            ls_cycle();
            for (int c = 0; c < 14; c++) begin
                pxl_cen   = ($urandom_range(0, 3) != 0);
                obj_valid = $urandom_range(0, 1);
                obj_y     = vpos - 8'($urandom_range(0, 24));
                obj_vflip = $urandom_range(0, 1);
                obj_data  = 20'($urandom);
                obj_last  = ($urandom_range(0, 9) == 0);
                rd_en     = $urandom_range(0, 1);
                rd_addr   = AW'($urandom);
                cycle();
            end
            idle_inputs();
            $display("random line %0d: vpos=%0h hits=%0d", ln, vpos, m_hits);
        end
        ls_cycle();
        for (int k = 0; k < 4; k++) read_cycle(AW'(k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
